// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Never returns 0 so a single-digit configuration still gets a 1-bit counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit digit_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder slice used by the serial datapath.
module digit_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[W];
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, with valid/ready handshakes on the operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int NDIG  = ndig(WIDTH, DIGIT);
  localparam int CNT_W = clog2_min1(NDIG);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
    $fatal(1, "serial_adder: DIGIT must divide WIDTH");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               a_sign_q, a_sign_d;
  logic               b_sign_q, b_sign_d;

  logic [DIGIT-1:0]   dig_sum;
  logic               dig_cout;
  logic               accept;

  digit_adder #(.W(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  assign accept = i_valid & o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(NDIG - 1)) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands drain from the bottom while finished digits enter the sum at the top.
  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    if (state_q == IDLE && accept) begin
      a_d      = i_a;
      b_d      = i_b;
      carry_d  = i_carry;
      a_sign_d = i_a[WIDTH-1];
      b_sign_d = i_b[WIDTH-1];
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
      carry_d = dig_cout;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    o_ready    = (state_q == IDLE) && i_rst_n;
    o_valid    = (state_q == DONE);
    o_busy     = (state_q == RUN);
    o_sum      = sum_q;
    o_carry    = carry_q;
    o_overflow = (a_sign_q == b_sign_q) && (sum_q[WIDTH-1] != a_sign_q);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one 32/4 instance plus 8-bit instances at DIGIT 4, 1, 2, 8.
module tb_serial_adder;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N-1:0] cin;
  logic [31:0]  a_in [N];
  logic [31:0]  b_in [N];
  wire  [N-1:0] out_ready;
  wire  [N-1:0] out_valid;
  wire  [N-1:0] out_carry;
  wire  [N-1:0] out_ovf;
  wire  [N-1:0] out_busy;
  wire  [31:0]  sum32;
  wire  [7:0]   sum8 [1:4];

  int total = 0;
  int bad   = 0;

  logic [31:0] m_sum;
  logic        m_carry;
  logic        m_ovf;

  always #5 clk = ~clk;

  serial_adder dut0 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (in_valid[0]),
    .o_ready    (out_ready[0]),
    .i_a        (a_in[0]),
    .i_b        (b_in[0]),
    .i_carry    (cin[0]),
    .o_valid    (out_valid[0]),
    .i_ready    (in_ready[0]),
    .o_sum      (sum32),
    .o_carry    (out_carry[0]),
    .o_overflow (out_ovf[0]),
    .o_busy     (out_busy[0])
  );

  for (genvar k = 1; k < N; k++) begin : g_dut8
    localparam int D = (k == 1) ? 4 : (k == 2) ? 1 : (k == 3) ? 2 : 8;
    serial_adder #(.WIDTH(8), .DIGIT(D)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (in_valid[k]),
      .o_ready    (out_ready[k]),
      .i_a        (a_in[k][7:0]),
      .i_b        (b_in[k][7:0]),
      .i_carry    (cin[k]),
      .o_valid    (out_valid[k]),
      .i_ready    (in_ready[k]),
      .o_sum      (sum8[k]),
      .o_carry    (out_carry[k]),
      .o_overflow (out_ovf[k]),
      .o_busy     (out_busy[k])
    );
  end

  function automatic int width_of(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic int ndig_of(input int k);
    case (k)
      0:       return 8;
      1:       return 2;
      2:       return 8;
      3:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] sum_of(input int k);
    if (k == 0) return sum32;
    return {24'h0, sum8[k]};
  endfunction

  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic c, output logic [31:0] s, output logic co,
                                output logic ov);
    logic [32:0] full;
    logic [31:0] m;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full = {1'b0, a & m} + {1'b0, b & m} + {32'h0, c};
    s    = full[31:0] & m;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic startOp(input int k, input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    checkOutput("ready_idle", out_ready[k], 1);
    in_valid[k] = 1'b1;
    a_in[k]     = a;
    b_in[k]     = b;
    cin[k]      = c;
    @(negedge clk);
    in_valid[k] = 1'b0;
    checkOutput("busy_run", out_busy[k], 1);
    checkOutput("ready_run", out_ready[k], 0);
  endtask

  // With inject set, new operands and i_valid are presented mid-run and must be ignored.
  task automatic waitResult(input int k, input bit inject, input logic [31:0] es,
                            input logic ec, input logic eo);
    int cycles;
    cycles = 0;
    while (out_valid[k] !== 1'b1 && cycles < 64) begin
      if (inject && cycles == 1) begin
        in_valid[k] = 1'b1;
        a_in[k]     = $urandom;
        b_in[k]     = $urandom;
      end
      if (inject && cycles == 3) in_valid[k] = 1'b0;
      @(negedge clk);
      cycles++;
    end
    checkOutput("latency", cycles, ndig_of(k));
    checkOutput("sum", sum_of(k), es);
    checkOutput("carry", out_carry[k], ec);
    checkOutput("overflow", out_ovf[k], eo);
    checkOutput("busy_done", out_busy[k], 0);
  endtask

  task automatic finishOp(input int k);
    @(negedge clk);
    checkOutput("valid_drop", out_valid[k], 0);
    checkOutput("ready_back", out_ready[k], 1);
  endtask

  task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic [31:0] es, input logic ec,
                               input logic eo);
    startOp(k, a, b, c);
    waitResult(k, 1'b0, es, ec, eo);
    finishOp(k);
  endtask

  initial begin
    logic [31:0] corners [4];
    logic [31:0] ra, rb;
    logic        rc;
    int          err_valid;

    corners[0] = 32'h00;
    corners[1] = 32'hFF;
    corners[2] = 32'h7F;
    corners[3] = 32'h80;

    rst_n    = 1'b0;
    in_valid = '0;
    in_ready = '1;
    cin      = '0;
    for (int k = 0; k < N; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", out_ready[1], 0);
    checkOutput("rst_valid", out_valid[1], 0);
    checkOutput("rst_busy", out_busy[1], 0);
    checkOutput("rst_sum", sum_of(1), 0);
    checkOutput("rst_carry", out_carry[1], 0);
    checkOutput("rst_ovf", out_ovf[1], 0);
    checkOutput("rst_sum32", sum32, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", out_ready[1], 1);

    applyStimulus(1, 32'h3C, 32'h05, 1'b0, 32'h41, 1'b0, 1'b0);

    applyStimulus(2, 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, 1'b0);
    applyStimulus(2, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1);
    applyStimulus(2, 32'h80, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1);

    applyStimulus(0, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

    in_ready[0] = 1'b0;
    startOp(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitResult(0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", out_valid[0], 1);
      checkOutput("hold_sum", sum32, 32'hFFFF_FFFF);
      checkOutput("hold_carry", out_carry[0], 1);
    end
    in_ready[0] = 1'b1;
    finishOp(0);

    startOp(0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    waitResult(0, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
    finishOp(0);

    startOp(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", out_valid[0], 0);
    checkOutput("abort_busy", out_busy[0], 0);
    checkOutput("abort_ready", out_ready[0], 0);
    checkOutput("abort_sum", sum32, 0);
    rst_n     = 1'b1;
    err_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) err_valid++;
    end
    checkOutput("abort_no_valid", err_valid, 0);
    applyStimulus(0, 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0);

    for (int k = 1; k < N; k++) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          rc = 1'((i + j) & 1);
          model(8, corners[i], corners[j], rc, m_sum, m_carry, m_ovf);
          applyStimulus(k, corners[i], corners[j], rc, m_sum, m_carry, m_ovf);
        end
      end
      for (int i = 0; i < 500; i++) begin
        ra = $urandom & 32'hFF;
        rb = $urandom & 32'hFF;
        rc = 1'($urandom & 1);
        model(width_of(k), ra, rb, rc, m_sum, m_carry, m_ovf);
        applyStimulus(k, ra, rb, rc, m_sum, m_carry, m_ovf);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
